stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that merges `NUM_SRC` ready/valid packet streams into one downstream ready/valid stream, typically feeding the shared `fifo_ready_valid` buffer. Arbitration is packet-atomic: once a source is granted, it keeps the output until it delivers a beat with `last` set. The output is registered through a one-entry slice. Each output beat is tagged with the index of its source.

## Interface
- `NUM_SRC`, 4, number of upstream sources (≥2, need not be a power of two)
- `DATA_WIDTH`, 8, payload width
- `IDX_W`, `$clog2(NUM_SRC)`, source-index width (localparam)
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `data_i`  in  NUM_SRC×DATA_WIDTH  per-source payload (unpacked array `[NUM_SRC]`)
- `last_i`  in  NUM_SRC  per-source end-of-packet flag
- `valid_i`  in  NUM_SRC  per-source valid
- `ready_o`  out  NUM_SRC  per-source ready (at most one bit high)
- `data_o`  out  DATA_WIDTH  output payload
- `last_o`  out  1  output end-of-packet
- `src_o`  out  IDX_W  source index of the current output beat
- `valid_o`  out  1  output valid
- `ready_i`  in  1  downstream ready
- `busy_o`  out  1  high while a packet grant is held

## Operation
- Reset (async assert, sync-safe deassert by the system):
  - state `IDLE`, `rr_ptr=0`, `grant_idx=0`
  - `valid_o=0`, `data_o=0`, `last_o=0`, `src_o=0`
  - `ready_o=0`, `busy_o=0`
- FSM states `IDLE` and `LOCKED`.
- `IDLE`:
  - `ready_o` is all zero.
  - If any `valid_i` is set, select the first set bit scanning from `rr_ptr` upward, wrapping modulo `NUM_SRC`.
  - Register the selection into `grant_idx` and go to `LOCKED`.
  - If no `valid_i` is set, stay in `IDLE`.
- `LOCKED`:
  - `busy_o=1`.
  - `slot_free = ~valid_o | ready_i`.
  - `ready_o[grant_idx] = slot_free`; all other `ready_o` bits are 0.
  - Input transfer: `valid_i[grant_idx] & ready_o[grant_idx]`. On transfer, the output slice loads `data_i[grant_idx]`, `last_i[grant_idx]` and `src_o=grant_idx`, and sets `valid_o=1`.
  - A transfer carrying `last_i=1` moves the FSM to `IDLE` and sets `rr_ptr = (grant_idx==NUM_SRC-1) ? 0 : grant_idx+1`.
- Output slice:
  - If `valid_o & ready_i` with no new load, then `valid_o` goes to 0.
  - Load and drain in the same cycle gives full throughput.
  - `data_o`, `last_o` and `src_o` are held stable while `valid_o & ~ready_i`.
- The grant holds indefinitely for a packet with no `last`. There is no timeout.
- `valid_i` of non-granted sources is ignored. Those sources must hold their data; their `ready_o` stays low.
- A granted source dropping `valid_i` mid-packet keeps the lock. There is no transfer that cycle.
- A single-beat packet (`last_i=1` on the first beat) is legal: lock, one transfer, back to `IDLE`.
- Reset mid-packet: the partial packet is discarded, including any beat held in the slice. The downstream sees `valid_o` fall asynchronously.

## Timing
- Request to grant: 1 cycle. `valid_i[k]` seen in `IDLE` at cycle 0 gives `ready_o[k]=1` in cycle 1 (slot free).
- Request to output: 2 cycles. The first beat is accepted at the end of cycle 1, and `valid_o=1` in cycle 2.
- Within a packet: 1 beat/cycle while `ready_i=1`.
- Between packets: exactly 1 input-side bubble cycle (the `IDLE` arbitration cycle). The output may still present the previous beat during it.
- `ready_o` depends combinationally on `ready_i` through `slot_free`. All other outputs are registered.

## Structure
- Package `stream_arb_pkg`:
  - `typedef enum logic {IDLE, LOCKED} arb_state_t`
  - `function rr_next(req, ptr)` returning the selected index with wrap-around
- Sub-module `stream_reg_slice`: one-entry ready/valid register for `{src, last, data}`. It is parameterised by width and uses the same async active-low reset.
- Top level holds the FSM, `rr_ptr`, `grant_idx` and `ready_o` decode.

## Test plan
- **Reset:** hold `rst_ni=0` with random `valid_i` -> all outputs 0, `ready_o=4'b0000`. Release -> `IDLE`, `busy_o=0`.
- **Single source:** src2 sends 3 beats `0x11,0x22,0x33` (last on 0x33) with `ready_i=1`.
  - Expect `ready_o=4'b0100` from cycle 1.
  - Expect `data_o` to be 0x11/0x22/0x33 in cycles 2–4 with `src_o=2`, and `last_o=1` only on 0x33.
- **Round-robin fairness:** all four sources continuously valid with 1-beat packets (`data=src idx`) -> output `src_o` sequence 0,1,2,3,0,1… with no repeats.
- **Wrap-around:** `rr_ptr=3` (after src2 finishes), then request src0 and src1 only -> src0 granted first, then src1.
- **Packet atomicity and backpressure:**
  - src1 sends 4 beats while src0 requests; `ready_i` toggles 1,0,0,1.
  - Expect all four src1 beats contiguous and stable during stalls, with no src0 beat until after src1's `last`.
  - Expect `ready_o[0]=0` throughout.
- **Reset mid-packet:** assert `rst_ni=0` after beat 2 of 5 from src3 -> `valid_o=0` immediately. After release, src3 re-requesting is granted from `rr_ptr=0` order.

Source files
------------

// File: rtl/stream_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared types and helpers for the round-robin packet stream arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE = arbitrate, LOCKED = packet held)
//   MAX_SRC     : largest source count the rr_next helper can scan
//   rr_next()   : round-robin pick of the first requester at or above a pointer
// -----------------------------------------------------------------------------
package stream_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Request vectors are zero-extended to this width before calling rr_next,
    // which keeps the helper independent of the arbiter's NUM_SRC parameter.
    localparam int MAX_SRC = 32;

    // Scan req starting at ptr, wrapping modulo num, and return the first set
    // index. When nothing is requested the pointer itself is returned; callers
    // only use the result when at least one request bit is set.
    function automatic int unsigned rr_next(
        input logic [MAX_SRC-1:0] req,
        input int unsigned        ptr,
        input int unsigned        num
    );
        int unsigned sel;
        int unsigned idx;
        logic        found;
        logic        in_range;
        logic        hit;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned i = 32'd0; i < MAX_SRC; i++) begin
            in_range = (i < num);
            idx      = ptr + i;
            idx      = (idx >= num) ? (idx - num) : idx;
            // Keep the index inside req for the unused tail of the scan.
            idx      = in_range ? idx : 32'd0;
            hit      = in_range & ~found & req[idx];
            sel      = hit ? idx : sel;
            found    = found | hit;
        end
        return sel;
    endfunction

endpackage : stream_arb_pkg

// File: rtl/stream_rr_arbiter_reg_slice.sv
// -----------------------------------------------------------------------------
// stream_reg_slice
// One-entry ready/valid register. Accepts a new word whenever the entry is
// empty or is being drained in the same cycle, so a continuous stream passes
// at one word per cycle. The held word is stable while out_valid_o is high
// and out_ready_i is low.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  : upstream handshake (in_ready_o is combinational
//                            on out_ready_i)
//   in_data_i              : upstream word
//   out_valid_o/out_ready_i: downstream handshake (out_valid_o registered)
//   out_data_o             : registered downstream word
// -----------------------------------------------------------------------------
module stream_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load_s;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign load_s      = in_valid_i & in_ready_o;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next-state of the entry: load wins over drain so load+drain keeps it full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_s) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
            data_d  = data_q;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Entry registers, cleared asynchronously so a held beat is discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule : stream_reg_slice

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
// Packet-atomic round-robin merge of NUM_SRC ready/valid streams into one
// registered output stream. A source, once granted, owns the output until it
// delivers a beat with last set; the next arbitration then starts scanning
// at the source after it. Each output beat carries its source index.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   data_i/last_i/valid_i : per-source payload, end-of-packet, valid
//   ready_o             : per-source ready, at most one bit set; depends
//                         combinationally on ready_i
//   data_o/last_o/src_o/valid_o : registered output beat and its source
//   ready_i             : downstream ready
//   busy_o              : a packet grant is currently held
// NUM_SRC must lie in 2..MAX_SRC (see stream_arb_pkg).
// -----------------------------------------------------------------------------
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int IDX_W      = $clog2(NUM_SRC)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i [NUM_SRC],
    input  logic [NUM_SRC-1:0]    last_i,
    input  logic [NUM_SRC-1:0]    valid_i,
    output logic [NUM_SRC-1:0]    ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic [IDX_W-1:0]      src_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o
);

    localparam int SLICE_W = IDX_W + 1 + DATA_WIDTH;

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      rr_ptr_d;
    logic [IDX_W-1:0]      grant_idx_q;
    logic [IDX_W-1:0]      grant_idx_d;
    logic [IDX_W-1:0]      sel_idx_s;
    logic [MAX_SRC-1:0]    req_ext_s;
    logic [NUM_SRC-1:0]    ready_s;
    logic                  slot_free_s;
    logic                  in_valid_s;
    logic                  in_last_s;
    logic [DATA_WIDTH-1:0] in_data_s;
    logic                  xfer_s;
    logic [SLICE_W-1:0]    slice_in_s;
    logic [SLICE_W-1:0]    slice_out_s;

    // Round-robin candidate for the next grant, scanned from rr_ptr.
    always_comb begin
        req_ext_s              = {MAX_SRC{1'b0}};
        req_ext_s[NUM_SRC-1:0] = valid_i;
        sel_idx_s              = IDX_W'(rr_next(req_ext_s, 32'(rr_ptr_q), 32'(NUM_SRC)));
    end

    // Only the granted source can present a beat; others are ignored.
    always_comb begin
        in_data_s  = data_i[grant_idx_q];
        in_last_s  = last_i[grant_idx_q];
        in_valid_s = (state_q == LOCKED) & valid_i[grant_idx_q];
    end

    assign xfer_s     = in_valid_s & slot_free_s;
    assign slice_in_s = {grant_idx_q, in_last_s, in_data_s};

    stream_reg_slice #(
        .WIDTH (SLICE_W)
    ) u_slice (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_s),
        .in_ready_o  (slot_free_s),
        .in_data_i   (slice_in_s),
        .out_valid_o (valid_o),
        .out_ready_i (ready_i),
        .out_data_o  (slice_out_s)
    );

    assign src_o  = slice_out_s[SLICE_W-1 -: IDX_W];
    assign last_o = slice_out_s[DATA_WIDTH];
    assign data_o = slice_out_s[DATA_WIDTH-1:0];
    assign busy_o = (state_q == LOCKED);

    // Per-source ready: only the granted source sees the slot-free signal.
    always_comb begin
        ready_s = {NUM_SRC{1'b0}};
        if (state_q == LOCKED) begin
            ready_s[grant_idx_q] = slot_free_s;
        end else begin
            ready_s = {NUM_SRC{1'b0}};
        end
    end

    assign ready_o = ready_s;

    // FSM next-state: grant in IDLE, release on the transfer carrying last.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        case (state_q)
            IDLE: begin
                if (|valid_i) begin
                    grant_idx_d = sel_idx_s;
                    state_d     = LOCKED;
                end else begin
                    state_d     = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s && in_last_s) begin
                    state_d  = IDLE;
                    // Explicit wrap: NUM_SRC need not be a power of two.
                    rr_ptr_d = (grant_idx_q == IDX_W'(NUM_SRC - 1))
                               ? {IDX_W{1'b0}}
                               : (grant_idx_q + IDX_W'(1));
                end else begin
                    state_d  = LOCKED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, round-robin pointer and grant registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= {IDX_W{1'b0}};
            grant_idx_q <= {IDX_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

endmodule : stream_rr_arbiter

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
// Directed, self-checking bench for stream_rr_arbiter (4 sources, 8-bit data).
// Inputs change 1 time unit after a rising edge; outputs are checked on the
// following falling edge. Expected values are hand-derived cycle tables.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    logic       clk;
    logic       rst_ni;
    logic [7:0] data_i [4];
    logic [3:0] last_i;
    logic [3:0] valid_i;
    logic [3:0] ready_o;
    logic [7:0] data_o;
    logic       last_o;
    logic [1:0] src_o;
    logic       valid_o;
    logic       ready_i;
    logic       busy_o;

    int checks;
    int errors;

    stream_rr_arbiter #(
        .NUM_SRC    (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .src_o   (src_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        ready_i = 1'b1;
        valid_i = 4'($urandom);
        last_i  = 4'($urandom);
        for (int k = 0; k < 4; k++) data_i[k] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last_o); end
        checks++; if (src_o !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", src_o); end
        checks++; if (ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        tick();
        rst_ni  = 1'b1;
        valid_i = 4'b0000;
        last_i  = 4'b0000;
        tick();
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", valid_o); end
        tick();
    endtask

    // src2 sends 0x11,0x22,0x33 (last on 0x33); rr_ptr ends at 3.
    task automatic test_single_source();
        logic [3:0] vin [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [7:0] din [6] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        logic       lin [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] erd [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic       ebz [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       evl [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] edt [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        logic       els [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            valid_i   = vin[c];
            data_i[2] = din[c];
            last_i    = {1'b0, lin[c], 2'b00};
            @(negedge clk);
            checks++; if (ready_o !== erd[c]) begin errors++; $display("FAIL single_ready c%0d got %b want %b", c, ready_o, erd[c]); end
            checks++; if (busy_o !== ebz[c]) begin errors++; $display("FAIL single_busy c%0d got %b want %b", c, busy_o, ebz[c]); end
            checks++; if (valid_o !== evl[c]) begin errors++; $display("FAIL single_valid c%0d got %b want %b", c, valid_o, evl[c]); end
            if (evl[c]) begin
                checks++; if (data_o !== edt[c]) begin errors++; $display("FAIL single_data c%0d got %h want %h", c, data_o, edt[c]); end
                checks++; if (last_o !== els[c]) begin errors++; $display("FAIL single_last c%0d got %b want %b", c, last_o, els[c]); end
                checks++; if (src_o !== 2'd2) begin errors++; $display("FAIL single_src c%0d got %0d want 2", c, src_o); end
            end
            tick();
        end
    endtask

    // rr_ptr=3; src0 and src1 request single beats -> src0 then src1.
    task automatic test_wraparound();
        logic [3:0] vin [6] = '{4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0] erd [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        logic       ebz [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       evl [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] esr [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        logic [7:0] edt [6] = '{8'h00, 8'h00, 8'hA0, 8'h00, 8'hB1, 8'h00};
        ready_i   = 1'b1;
        data_i[0] = 8'hA0;
        data_i[1] = 8'hB1;
        last_i    = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            valid_i = vin[c];
            @(negedge clk);
            checks++; if (ready_o !== erd[c]) begin errors++; $display("FAIL wrap_ready c%0d got %b want %b", c, ready_o, erd[c]); end
            checks++; if (busy_o !== ebz[c]) begin errors++; $display("FAIL wrap_busy c%0d got %b want %b", c, busy_o, ebz[c]); end
            checks++; if (valid_o !== evl[c]) begin errors++; $display("FAIL wrap_valid c%0d got %b want %b", c, valid_o, evl[c]); end
            if (evl[c]) begin
                checks++; if (src_o !== esr[c]) begin errors++; $display("FAIL wrap_src c%0d got %0d want %0d", c, src_o, esr[c]); end
                checks++; if (data_o !== edt[c]) begin errors++; $display("FAIL wrap_data c%0d got %h want %h", c, data_o, edt[c]); end
            end
            tick();
        end
    endtask

    // Fresh reset, then all sources send 1-beat packets: src_o 0,1,2,3,0,1,2,3.
    task automatic test_fairness();
        int n;
        rst_ni = 1'b0;
        tick();
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) data_i[k] = 8'(k);
        last_i  = 4'b1111;
        valid_i = 4'b1111;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                checks++; if (src_o !== 2'(n % 4)) begin errors++; $display("FAIL rr_src beat%0d got %0d want %0d", n, src_o, n % 4); end
                checks++; if (data_o !== 8'(n % 4)) begin errors++; $display("FAIL rr_data beat%0d got %h want %h", n, data_o, 8'(n % 4)); end
                n++;
            end
            if (n == 8) valid_i = 4'b0000;
            tick();
        end
        checks++; if (n != 8) begin errors++; $display("FAIL rr_timeout beats got %0d want 8", n); end
        valid_i = 4'b0000;
        tick();
    endtask

    // src1 sends 4 beats under backpressure while src0 waits.
    task automatic test_atomicity_backpressure();
        logic [3:0] vin [10] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                                 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
        logic [7:0] d1  [10] = '{8'hD0, 8'hD0, 8'hD1, 8'hD2, 8'hD2,
                                 8'hD2, 8'hD3, 8'h00, 8'h00, 8'h00};
        logic       l1  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       rdi [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] erd [10] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
        logic       ebz [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       evl [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] edt [10] = '{8'h00, 8'h00, 8'hD0, 8'hD1, 8'hD1,
                                 8'hD1, 8'hD2, 8'hD3, 8'h00, 8'hE0};
        logic [1:0] esr [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        logic       els [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        data_i[0] = 8'hE0;
        for (int c = 0; c < 10; c++) begin
            valid_i   = vin[c];
            data_i[1] = d1[c];
            last_i    = {2'b00, l1[c], 1'b1};
            ready_i   = rdi[c];
            @(negedge clk);
            checks++; if (ready_o !== erd[c]) begin errors++; $display("FAIL atom_ready c%0d got %b want %b", c, ready_o, erd[c]); end
            checks++; if (busy_o !== ebz[c]) begin errors++; $display("FAIL atom_busy c%0d got %b want %b", c, busy_o, ebz[c]); end
            checks++; if (valid_o !== evl[c]) begin errors++; $display("FAIL atom_valid c%0d got %b want %b", c, valid_o, evl[c]); end
            if (evl[c]) begin
                checks++; if (data_o !== edt[c]) begin errors++; $display("FAIL atom_data c%0d got %h want %h", c, data_o, edt[c]); end
                checks++; if (src_o !== esr[c]) begin errors++; $display("FAIL atom_src c%0d got %0d want %0d", c, src_o, esr[c]); end
                checks++; if (last_o !== els[c]) begin errors++; $display("FAIL atom_last c%0d got %b want %b", c, last_o, els[c]); end
            end
            tick();
        end
        ready_i = 1'b1;
    endtask

    // src3 packet cut by reset after two beats; afterwards arbitration restarts at 0.
    task automatic test_reset_mid_packet();
        logic [7:0] d3  [4] = '{8'h30, 8'h30, 8'h31, 8'h32};
        logic [3:0] erd [4] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000};
        logic       evl [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] edt [4] = '{8'h00, 8'h00, 8'h30, 8'h31};
        logic [3:0] vin2 [5] = '{4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b0000};
        logic [3:0] erd2 [5] = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
        logic       evl2 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] edt2 [5] = '{8'h00, 8'h00, 8'h0A, 8'h00, 8'h30};
        logic [1:0] esr2 [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
        ready_i = 1'b1;
        last_i  = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            valid_i   = 4'b1000;
            data_i[3] = d3[c];
            @(negedge clk);
            checks++; if (ready_o !== erd[c]) begin errors++; $display("FAIL mid_ready c%0d got %b want %b", c, ready_o, erd[c]); end
            checks++; if (valid_o !== evl[c]) begin errors++; $display("FAIL mid_valid c%0d got %b want %b", c, valid_o, evl[c]); end
            if (evl[c]) begin
                checks++; if (data_o !== edt[c]) begin errors++; $display("FAIL mid_data c%0d got %h want %h", c, data_o, edt[c]); end
            end
            if (c < 3) tick();
        end
        rst_ni = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy_o); end
        checks++; if (ready_o !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b want 0000", ready_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h want 00", data_o); end
        tick();
        tick();
        rst_ni    = 1'b1;
        data_i[0] = 8'h0A;
        data_i[3] = 8'h30;
        last_i    = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            valid_i = vin2[c];
            @(negedge clk);
            checks++; if (ready_o !== erd2[c]) begin errors++; $display("FAIL post_ready c%0d got %b want %b", c, ready_o, erd2[c]); end
            checks++; if (valid_o !== evl2[c]) begin errors++; $display("FAIL post_valid c%0d got %b want %b", c, valid_o, evl2[c]); end
            if (evl2[c]) begin
                checks++; if (data_o !== edt2[c]) begin errors++; $display("FAIL post_data c%0d got %h want %h", c, data_o, edt2[c]); end
                checks++; if (src_o !== esr2[c]) begin errors++; $display("FAIL post_src c%0d got %0d want %0d", c, src_o, esr2[c]); end
            end
            tick();
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_ni  = 1'b0;
        valid_i = 4'b0000;
        last_i  = 4'b0000;
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) data_i[k] = 8'h00;
        test_reset();
        test_single_source();
        test_wraparound();
        test_fairness();
        test_atomicity_backpressure();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stream_rr_arbiter
